// File: rtl/control_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcode classes,
// opcode values and the mux/ALU select codes driven onto the datapath.
package control_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BEQ, CLS_J, CLS_HALT
    } op_class_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_4     = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/opcode_classify.sv
// Combinational opcode decoder: maps the IR opcode onto an instruction class
// and flags anything outside the supported set.
module opcode_classify
    import control_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] instr_opcode,
    output op_class_e           op_class,
    output logic                illegal
);

    always_comb begin
        op_class = CLS_HALT;
        illegal  = 1'b0;
        case (instr_opcode)
            OPCODE_W'(OP_RTYPE):                    op_class = CLS_R;
            OPCODE_W'(OP_ADDI), OPCODE_W'(OP_ADDIU): op_class = CLS_I;
            OPCODE_W'(OP_LW):                       op_class = CLS_LW;
            OPCODE_W'(OP_SW):                       op_class = CLS_SW;
            OPCODE_W'(OP_BEQ):                      op_class = CLS_BEQ;
            OPCODE_W'(OP_J):                        op_class = CLS_J;
            OPCODE_W'(OP_HALT):                     op_class = CLS_HALT;
            default:                                illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM with sticky halt/illegal flags and a
// retired-instruction counter.
module multicycle_control
    import control_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] instr_opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                iord,
    output logic                ir_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_source,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                halted,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    instr_count
);

    state_e    state_q, state_d;
    op_class_e cls_q, dec_class;
    logic      dec_illegal;
    logic      retire;

    opcode_classify #(.OPCODE_W(OPCODE_W)) u_classify (
        .instr_opcode (instr_opcode),
        .op_class     (dec_class),
        .illegal      (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            illegal_op  <= 1'b0;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE && dec_illegal)
                illegal_op <= 1'b1;
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    // The class is captured once in DECODE so later opcode changes are ignored.
    always_ff @(posedge clk) begin
        if (state_q == S_DECODE)
            cls_q <= dec_class;
    end

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        pc_source     = PCSRC_ALU;
        alu_op        = ALUOP_W'(ALUOP_ADD);
        halted        = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_4;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_SHIMM;
                case (dec_class)
                    CLS_R:          state_d = S_EXEC_R;
                    CLS_I:          state_d = S_EXEC_I;
                    CLS_LW, CLS_SW: state_d = S_MEM_ADDR;
                    CLS_BEQ:        state_d = S_BRANCH;
                    CLS_J:          state_d = S_JUMP;
                    default:        state_d = S_HALT;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_B;
                alu_op    = ALUOP_W'(ALUOP_FUNCT);
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = (cls_q == CLS_R);
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (cls_q == CLS_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready)
                    state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_B;
                alu_op        = ALUOP_W'(ALUOP_SUB);
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_FETCH;
        endcase
        // A cycle under reset abandons any access, so no architectural write strobes escape.
        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: OPCODE_W, 6, opcode width; ALUOP_W, 2, ALU-op field width; CNT_W, 32, retired-instruction counter width.
REQ-002 Ports SHALL be exactly (name  direction  width  meaning):
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- instr_opcode  in  OPCODE_W  opcode of the instruction register, sampled in DECODE.
- mem_ready  in  1  memory handshake; the current access completes in a cycle where it is high.
- pc_write, pc_write_cond, iord, ir_write  out  1 each  PC update, branch-qualified PC update, data-vs-instruction address select, IR load.
- mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath controls.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended immediate.
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- alu_op  out  ALUOP_W  00 = add, 01 = sub, 10 = funct-decoded.
- halted  out  1  sticky halt indication.
- illegal_op  out  1  sticky unknown-opcode flag.
- instr_count  out  CNT_W  retired-instruction count.

Function
REQ-003 The FSM states SHALL be FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, HALT.
REQ-004 FETCH SHALL assert mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write SHALL be asserted only in a FETCH cycle with mem_ready=1. The FSM SHALL stay in FETCH while mem_ready=0 and move to DECODE on mem_ready=1.
REQ-005 DECODE SHALL drive alu_src_a=0, alu_src_b=11 (branch-offset precompute) and branch on instr_opcode:
- 0x00 -> EXEC_R
- 0x08 or 0x09 -> EXEC_I
- 0x23 or 0x2B -> MEM_ADDR
- 0x04 -> BRANCH
- 0x02 -> JUMP
- 0x3F -> HALT
- any other value -> HALT, with illegal_op set.
REQ-006 alu_src_b SHALL be 2 bits; code 11 selects the shifted immediate.
REQ-007 EXEC_R SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10, then go to ALU_WB.
REQ-008 EXEC_I SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to ALU_WB.
REQ-009 ALU_WB SHALL assert reg_write=1, with reg_dst=1 only for an R-type instruction and mem_to_reg=0, then go to FETCH.
REQ-010 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to MEM_RD for lw or MEM_WR for sw.
REQ-011 MEM_RD SHALL assert mem_read=1, iord=1 and hold until mem_ready=1, then go to MEM_WB.
REQ-012 MEM_WB SHALL assert reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-013 MEM_WR SHALL assert mem_write=1, iord=1 and hold until mem_ready=1, then go to FETCH.
REQ-014 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, then go to FETCH.
REQ-015 JUMP SHALL drive pc_write=1, pc_source=10, then go to FETCH.
REQ-016 In any state, every output not explicitly driven SHALL be 0.
REQ-017 The opcode class SHALL be latched in DECODE; later states SHALL ignore changes on instr_opcode.
REQ-018 Latency with mem_ready tied to 1 SHALL be:
- R-type, addi, addiu, sw: 4 cycles.
- lw: 5 cycles.
- beq, j: 3 cycles.
- Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
REQ-019 instr_count SHALL increment by 1 on the final cycle of each instruction (ALU_WB, MEM_WB, the completing MEM_WR, BRANCH, JUMP). It SHALL wrap from all-ones to 0 and SHALL NOT count HALT.
REQ-020 HALT SHALL be absorbing: halted=1, all datapath controls 0, mem_ready ignored, exit only through rst.
REQ-021 illegal_op SHALL be set only in the DECODE cycle that sees an unknown opcode, and SHALL hold until rst.

Reset
REQ-022 When rst=1 at a rising edge, the next state SHALL be FETCH, and halted, illegal_op and instr_count SHALL be 0, regardless of current state or mem_ready.
REQ-023 Reset during a pending memory wait SHALL abandon the access; no pc_write, ir_write or reg_write SHALL occur in the cycle after reset.
REQ-024 The first FETCH after rst deasserts SHALL behave exactly as defined in REQ-004.

Structure
REQ-025 The state encoding, the opcode constants (0x00, 0x02, 0x04, 0x08, 0x09, 0x23, 0x2B, 0x3F) and the alu_src_b, pc_source and alu_op codes SHALL reside in a shared package, control_pkg.
REQ-026 Opcode classification SHALL be a combinational sub-module, opcode_classify, with inputs instr_opcode and outputs class and illegal.
REQ-027 The FSM, the sticky flags and instr_count SHALL be in multicycle_control.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- rst held 2 cycles, then opcode 0x00 with mem_ready=1 -> FETCH, DECODE, EXEC_R, ALU_WB; reg_write=1 and reg_dst=1 in cycle 4; instr_count=1.
- lw (0x23) with mem_ready low for 2 cycles in MEM_RD -> 7 cycles total; mem_read=1 and iord=1 held throughout the wait; mem_to_reg=1 in MEM_WB.
- beq (0x04) then j (0x02) -> 3 cycles each; pc_write_cond=1 with pc_source=01, then pc_write=1 with pc_source=10; instr_count=2.
- opcode 0x3F -> halted=1 from the cycle after DECODE; 10 further cycles with mem_ready toggling -> no control asserted, instr_count unchanged.
- opcode 0x15 -> illegal_op=1 and halted=1; rst -> both 0 and state FETCH.
- rst asserted mid-MEM_WR with mem_ready=0 -> no mem_write completion counted; FETCH next cycle; instr_count=0.
